// File: rtl/video_timing_pkg.sv
// Shared raster constants and coordinate types for the timing generator and the renderers.
package video_timing_pkg;

  localparam int unsigned H_ACTIVE_720P = 1280;
  localparam int unsigned H_FP_720P     = 110;
  localparam int unsigned H_SYNC_720P   = 40;
  localparam int unsigned H_BP_720P     = 220;
  localparam int unsigned V_ACTIVE_720P = 720;
  localparam int unsigned V_FP_720P     = 5;
  localparam int unsigned V_SYNC_720P   = 5;
  localparam int unsigned V_BP_720P     = 20;

  localparam int unsigned H_TOTAL = H_ACTIVE_720P + H_FP_720P + H_SYNC_720P + H_BP_720P;
  localparam int unsigned V_TOTAL = V_ACTIVE_720P + V_FP_720P + V_SYNC_720P + V_BP_720P;

  localparam int unsigned HCOUNT_W = 11;
  localparam int unsigned VCOUNT_W = 10;
  localparam int unsigned FRAME_W  = 6;

  typedef logic [HCOUNT_W-1:0] hcount_t;
  typedef logic [VCOUNT_W-1:0] vcount_t;
  typedef logic [FRAME_W-1:0]  frame_t;

endpackage

// File: rtl/wrap_counter.sv
// Counter that advances on incr_i and wraps from MaxVal back to zero.
module wrap_counter #(
  parameter int unsigned Width  = 11,
  parameter int unsigned MaxVal = 1649
) (
  input  logic             clk_i,
  input  logic             rst_in,
  input  logic             incr_i,
  output logic [Width-1:0] count_o,
  output logic             at_max_o
);

  logic [Width-1:0] count_q, count_d;

  assign at_max_o = (count_q == Width'(MaxVal));
  assign count_o  = count_q;

  always_comb begin
    count_d = count_q;
    if (incr_i) begin
      count_d = at_max_o ? '0 : count_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_in) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing source: pixel coordinates, syncs, active flag and per-frame pulse/counter,
// all registered from the same (h, v) so no output is skewed against another.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_720P,
  parameter int unsigned H_FP     = H_FP_720P,
  parameter int unsigned H_SYNC   = H_SYNC_720P,
  parameter int unsigned H_BP     = H_BP_720P,
  parameter int unsigned V_ACTIVE = V_ACTIVE_720P,
  parameter int unsigned V_FP     = V_FP_720P,
  parameter int unsigned V_SYNC   = V_SYNC_720P,
  parameter int unsigned V_BP     = V_BP_720P,
  parameter int unsigned SYNC_POL = 1
) (
  input  logic                pixel_clk_in,
  input  logic                rst_in,
  output logic [HCOUNT_W-1:0] hcount_out,
  output logic [VCOUNT_W-1:0] vcount_out,
  output logic                hsync_out,
  output logic                vsync_out,
  output logic                active_draw_out,
  output logic                new_frame_out,
  output logic [FRAME_W-1:0]  frame_count_out
);

  localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (HTotal > 2048) begin : g_h_total_chk
    $error("video_timing_gen: horizontal total exceeds 2048");
  end
  if (VTotal > 1024) begin : g_v_total_chk
    $error("video_timing_gen: vertical total exceeds 1024");
  end

  // Sync windows use inclusive last positions so the bound always fits the counter width.
  localparam hcount_t HActive    = hcount_t'(H_ACTIVE);
  localparam hcount_t HSyncFirst = hcount_t'(H_ACTIVE + H_FP);
  localparam hcount_t HSyncLast  = hcount_t'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam vcount_t VActive    = vcount_t'(V_ACTIVE);
  localparam vcount_t VSyncFirst = vcount_t'(V_ACTIVE + V_FP);
  localparam vcount_t VSyncLast  = vcount_t'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic    SyncInv    = (SYNC_POL == 0) ? 1'b1 : 1'b0;

  hcount_t h;
  vcount_t v;
  logic    h_at_max;
  logic    v_at_max_unused;

  wrap_counter #(
    .Width  (HCOUNT_W),
    .MaxVal (HTotal - 1)
  ) u_h_cnt (
    .clk_i    (pixel_clk_in),
    .rst_in   (rst_in),
    .incr_i   (1'b1),
    .count_o  (h),
    .at_max_o (h_at_max)
  );

  wrap_counter #(
    .Width  (VCOUNT_W),
    .MaxVal (VTotal - 1)
  ) u_v_cnt (
    .clk_i    (pixel_clk_in),
    .rst_in   (rst_in),
    .incr_i   (h_at_max),
    .count_o  (v),
    .at_max_o (v_at_max_unused)
  );

  hcount_t hcount_q;
  vcount_t vcount_q;
  frame_t  frame_q, frame_d;
  logic    hsync_q, hsync_d;
  logic    vsync_q, vsync_d;
  logic    active_q, active_d;
  logic    new_frame_q, new_frame_d;

  always_comb begin
    active_d    = (h < HActive) && (v < VActive);
    hsync_d     = ((h >= HSyncFirst) && (h <= HSyncLast)) ^ SyncInv;
    vsync_d     = ((v >= VSyncFirst) && (v <= VSyncLast)) ^ SyncInv;
    new_frame_d = (h == HActive) && (v == VActive);
    // Counter advances alongside the pulse so both appear in the same output cycle.
    frame_d     = new_frame_d ? frame_q + 1'b1 : frame_q;
  end

  always_ff @(posedge pixel_clk_in) begin
    if (!rst_in) begin
      hcount_q    <= '0;
      vcount_q    <= '0;
      hsync_q     <= SyncInv;
      vsync_q     <= SyncInv;
      active_q    <= 1'b0;
      new_frame_q <= 1'b0;
      frame_q     <= '0;
    end else begin
      hcount_q    <= h;
      vcount_q    <= v;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      active_q    <= active_d;
      new_frame_q <= new_frame_d;
      frame_q     <= frame_d;
    end
  end

  assign hcount_out      = hcount_q;
  assign vcount_out      = vcount_q;
  assign hsync_out       = hsync_q;
  assign vsync_out       = vsync_q;
  assign active_draw_out = active_q;
  assign new_frame_out   = new_frame_q;
  assign frame_count_out = frame_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen on a reduced 25x13 raster, both sync polarities.
module tb_video_timing_gen;

  localparam int HA = 16;
  localparam int HF = 2;
  localparam int HS = 3;
  localparam int HB = 4;
  localparam int VA = 8;
  localparam int VF = 1;
  localparam int VS = 2;
  localparam int VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  // Tag bits attached to a scoreboard entry.
  localparam int TagClr   = 1;
  localparam int TagLine  = 2;
  localparam int TagFrame = 4;
  localparam int TagNoNf  = 8;
  localparam int TagHand  = 16;

  typedef struct packed {
    logic [10:0] h;
    logic [9:0]  v;
    logic        hs;
    logic        vs;
    logic        act;
    logic        nf;
    logic [5:0]  fc;
  } vec_t;

  typedef struct packed {
    vec_t mdl;
    int   tag;
    vec_t hand;
  } item_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] hcount, hcount0;
  logic [9:0]  vcount, vcount0;
  logic        hsync, hsync0, vsync, vsync0;
  logic        act, act0, nf, nf0;
  logic [5:0]  fc, fc0;

  always #5 clk = ~clk;

  video_timing_gen #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .SYNC_POL (1)
  ) u_dut (
    .pixel_clk_in    (clk),
    .rst_in          (rst_n),
    .hcount_out      (hcount),
    .vcount_out      (vcount),
    .hsync_out       (hsync),
    .vsync_out       (vsync),
    .active_draw_out (act),
    .new_frame_out   (nf),
    .frame_count_out (fc)
  );

  video_timing_gen #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .SYNC_POL (0)
  ) u_dut_neg (
    .pixel_clk_in    (clk),
    .rst_in          (rst_n),
    .hcount_out      (hcount0),
    .vcount_out      (vcount0),
    .hsync_out       (hsync0),
    .vsync_out       (vsync0),
    .active_draw_out (act0),
    .new_frame_out   (nf0),
    .frame_count_out (fc0)
  );

  item_t q[$];
  int    n_checks = 0;
  int    n_fail = 0;
  int    mh = 0, mv = 0, mfc = 0;

  function automatic string vstr(input vec_t x);
    return $sformatf("h=%0d v=%0d hs=%b vs=%b act=%b nf=%b fc=%0d",
                     x.h, x.v, x.hs, x.vs, x.act, x.nf, x.fc);
  endfunction

  function automatic vec_t hv(input int h, input int v, input logic a, input logic n, input int f);
    vec_t x = '0;
    x.h   = 11'(h);
    x.v   = 10'(v);
    x.act = a;
    x.nf  = n;
    x.fc  = 6'(f);
    return x;
  endfunction

  // Pushes the expected output for the coming rising edge, then waits past it.
  task automatic drive(input logic r, input int tag, input vec_t hand);
    item_t it;
    vec_t  e = '0;
    rst_n = r;
    if (r) begin
      e.h   = 11'(mh);
      e.v   = 10'(mv);
      e.act = (mh < HA) && (mv < VA);
      e.hs  = (mh >= HA + HF) && (mh < HA + HF + HS);
      e.vs  = (mv >= VA + VF) && (mv < VA + VF + VS);
      e.nf  = (mh == HA) && (mv == VA);
      if (e.nf) mfc = (mfc + 1) % 64;
      e.fc  = 6'(mfc);
      if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh = mh + 1;
      end
    end else begin
      mh  = 0;
      mv  = 0;
      mfc = 0;
    end
    it.mdl  = e;
    it.tag  = tag;
    it.hand = hand;
    q.push_back(it);
    @(negedge clk);
  endtask

  task automatic step(input int n);
    repeat (n) drive(1'b1, 0, '0);
  endtask

  task automatic chk(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  item_t it_m;
  vec_t  got, got0;
  int    act_c = 0, hs_c = 0, vs_c = 0, nf_c = 0;
  int    hs_rise = -1, hs_last = -1, vs_rise = -1, vs_last = -1;
  int    nf_h = -1, nf_v = -1, nf_fc = -1;
  logic  hs_prev = 1'b0, vs_prev = 1'b0;

  always @(posedge clk) begin
    #1;
    if (q.size() != 0) begin
      it_m = q.pop_front();
      got  = {hcount, vcount, hsync, vsync, act, nf, fc};
      got0 = {hcount0, vcount0, ~hsync0, ~vsync0, act0, nf0, fc0};
      n_checks++;
      if (got !== it_m.mdl) begin
        n_fail++;
        $display("FAIL cycle_vec: got %s, want %s", vstr(got), vstr(it_m.mdl));
      end
      n_checks++;
      if (got0 !== it_m.mdl) begin
        n_fail++;
        $display("FAIL neg_pol_vec (syncs shown re-inverted): got %s, want %s",
                 vstr(got0), vstr(it_m.mdl));
      end
      if ((it_m.tag & TagClr) != 0) begin
        act_c = 0; hs_c = 0; vs_c = 0; nf_c = 0;
        hs_rise = -1; hs_last = -1; vs_rise = -1; vs_last = -1;
        nf_h = -1; nf_v = -1; nf_fc = -1;
        hs_prev = 1'b0; vs_prev = 1'b0;
      end
      if (got.act) act_c++;
      if (got.hs) begin
        if (!hs_prev) hs_rise = int'(got.h);
        hs_last = int'(got.h);
        hs_c++;
      end
      if (got.vs) begin
        if (!vs_prev) vs_rise = int'(got.v);
        vs_last = int'(got.v);
        vs_c++;
      end
      hs_prev = got.hs;
      vs_prev = got.vs;
      if (got.nf) begin
        nf_c++;
        nf_h  = int'(got.h);
        nf_v  = int'(got.v);
        nf_fc = int'(got.fc);
      end
      if ((it_m.tag & TagHand) != 0) begin
        chk("hand_hcount", int'(got.h), int'(it_m.hand.h));
        chk("hand_vcount", int'(got.v), int'(it_m.hand.v));
        chk("hand_active", int'(got.act), int'(it_m.hand.act));
        chk("hand_new_frame", int'(got.nf), int'(it_m.hand.nf));
        chk("hand_frame_count", int'(got.fc), int'(it_m.hand.fc));
      end
      if ((it_m.tag & TagLine) != 0) begin
        chk("line_hsync_cycles", hs_c, HS);
        chk("line_hsync_first_h", hs_rise, HA + HF);
        chk("line_hsync_last_h", hs_last, HA + HF + HS - 1);
      end
      if ((it_m.tag & TagFrame) != 0) begin
        chk("frame_active_cycles", act_c, HA * VA);
        chk("frame_vsync_cycles", vs_c, VS * HT);
        chk("frame_vsync_first_v", vs_rise, VA + VF);
        chk("frame_vsync_last_v", vs_last, VA + VF + VS - 1);
        chk("frame_new_frame_pulses", nf_c, 1);
        chk("frame_new_frame_h", nf_h, HA);
        chk("frame_new_frame_v", nf_v, VA);
        chk("frame_new_frame_count", nf_fc, 1);
      end
      if ((it_m.tag & TagNoNf) != 0) begin
        chk("midreset_no_new_frame", nf_c, 0);
      end
    end
  end

  initial begin
    @(negedge clk);
    // Reset held for 5 cycles.
    repeat (4) drive(1'b0, 0, '0);
    drive(1'b0, TagHand, hv(0, 0, 1'b0, 1'b0, 0));
    // Release; cycle index 0 is the first output after release.
    drive(1'b1, TagClr | TagHand, hv(0, 0, 1'b1, 1'b0, 0));
    drive(1'b1, TagHand, hv(1, 0, 1'b1, 1'b0, 0));
    step(22);
    drive(1'b1, TagLine | TagHand, hv(24, 0, 1'b0, 1'b0, 0));
    drive(1'b1, TagHand, hv(0, 1, 1'b1, 1'b0, 0));
    // Run out the rest of frame 0: cycles 26..323, then the last pixel at 324.
    step(298);
    drive(1'b1, TagFrame | TagHand, hv(24, 12, 1'b0, 1'b0, 1));
    drive(1'b1, TagHand, hv(0, 0, 1'b1, 1'b0, 1));
    // Cycles 326..20689, then the pixel before the 64th frame pulse.
    step(20364);
    drive(1'b1, TagHand, hv(15, 8, 1'b0, 1'b0, 63));
    drive(1'b1, TagHand, hv(16, 8, 1'b0, 1'b1, 0));
    // Advance to (7, 5) of the next frame, then reset mid-frame.
    step(240);
    drive(1'b1, TagClr | TagHand, hv(7, 5, 1'b1, 1'b0, 0));
    drive(1'b0, TagNoNf | TagHand, hv(0, 0, 1'b0, 1'b0, 0));
    drive(1'b1, TagHand, hv(0, 0, 1'b1, 1'b0, 0));
    drive(1'b1, TagHand, hv(1, 0, 1'b1, 1'b0, 0));
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Generates the raster timing that drives the sprite and map renderers: pixel coordinates, sync pulses, active-region flag, and a once-per-frame pulse with a frame counter. It is the source end of the hcount/vcount interface consumed by `map_sprite_3` and the other pixel-pipeline stages. It sits directly after the pixel clock and feeds both the renderers and the HDMI/TMDS encoder. Default parameters give 1280x720 at 60 Hz on a 74.25 MHz pixel clock.

## Interface

Parameters:
- `H_ACTIVE`, default 1280: visible pixels per line.
- `H_FP`, default 110: horizontal front porch, in pixels.
- `H_SYNC`, default 40: hsync width, in pixels.
- `H_BP`, default 220: horizontal back porch; total line is 1650.
- `V_ACTIVE`, default 720: visible lines per frame.
- `V_FP`, default 5: vertical front porch, in lines.
- `V_SYNC`, default 5: vsync width, in lines.
- `V_BP`, default 20: vertical back porch; total frame is 750 lines.
- `SYNC_POL`, default 1: 1 means active-high syncs; 0 inverts both `hsync_out` and `vsync_out`.

Ports:
- `pixel_clk_in`  in  1  pixel clock; the only clock.
- `rst_in`  in  1  synchronous, active-low reset.
- `hcount_out`  out  11  horizontal position, 0..1649.
- `vcount_out`  out  10  vertical position, 0..749.
- `hsync_out`  out  1  horizontal sync.
- `vsync_out`  out  1  vertical sync.
- `active_draw_out`  out  1  high inside the visible region.
- `new_frame_out`  out  1  one-cycle pulse per frame.
- `frame_count_out`  out  6  frame index; wraps 63 to 0.

## Operation

- Internal counters `h` (0..H_TOTAL-1) and `v` (0..V_TOTAL-1).
  - `h` increments every cycle.
  - When `h == H_TOTAL-1`, `h` goes to 0 and `v` increments.
  - When `v == V_TOTAL-1` and `h == H_TOTAL-1`, both go to 0.
- All outputs are registered decodes of `(h, v)`:
  - `hcount_out = h`, `vcount_out = v`.
  - `active_draw_out = (h < H_ACTIVE) && (v < V_ACTIVE)`.
  - `hsync_out` asserted (per `SYNC_POL`) for `h` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), i.e. [1390, 1430).
  - `vsync_out` asserted for `v` in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), i.e. [725, 730). The vsync span covers whole lines, independent of `h`.
  - `new_frame_out = (h == H_ACTIVE) && (v == V_ACTIVE)`, i.e. the first blanking pixel after the last visible line.
  - `frame_count_out` increments in the same cycle that `new_frame_out` is presented, so the new value and the pulse appear together.
- Width rules:
  - All compares are unsigned, at the counter widths.
  - Parameters must satisfy H_TOTAL ≤ 2048 and V_TOTAL ≤ 1024; elaboration asserts this.
- Reset (`rst_in` low at a rising edge):
  - Next cycle: `h`, `v` = 0, and every output = 0, including `active_draw_out`, `frame_count_out` and `new_frame_out`.
  - The syncs take the deasserted level for `SYNC_POL`, so they are 0 only when `SYNC_POL` = 1.
  - Reset mid-frame abandons the frame; no `new_frame_out` pulse is emitted.
  - The counters hold at 0 for as long as reset is held.

## Timing

- Output latency: one cycle from internal counter state. All outputs in a cycle describe the same `(h, v)`; no output is skewed against another.
- First rising edge with `rst_in` high presents `hcount_out=0`, `vcount_out=0`, `active_draw_out=1`. The internal state advances to (1, 0).
- Line period: 1650 cycles. Frame period: 1,237,500 cycles.
- `new_frame_out` is high for exactly one cycle per frame.
- Line and frame wrap happen in the same cycle: (1649, 749) → (0, 0).
- Downstream stages must pipeline `hcount_out`/`vcount_out` to match their own latency; this block provides no delayed copies.

## Structure

- Package `video_timing_pkg`:
  - 720p constants `H_ACTIVE_720P`..`V_BP_720P`.
  - Derived `H_TOTAL` and `V_TOTAL`.
  - Widths `HCOUNT_W = 11`, `VCOUNT_W = 10`.
  - Typedefs `hcount_t` and `vcount_t`.
  - Renderers import the same package.
- One sub-module, `wrap_counter`: parameterized max, with inputs `incr`, `rst_in` and output `at_max`. It is instantiated twice, for the horizontal (`incr = 1`) and vertical (`incr = h at_max`) counters.
- Output decode and registering live in the top module.

## Test plan

- Reset behaviour: hold `rst_in` low 5 cycles → all outputs 0. Release → first cycle `hcount_out=0`, `vcount_out=0`, `active_draw_out=1`. Second cycle `hcount_out=1`.
- Line wrap: run to `hcount_out=1649`, `vcount_out=0` → next cycle `hcount_out=0`, `vcount_out=1`. Over one line, `hsync_out` is high for exactly 40 cycles, at `hcount_out` 1390..1429.
- Frame wrap: run a full frame from reset:
  - `new_frame_out` pulses once, at (1280, 720), with `frame_count_out` going 0 → 1.
  - (1649, 749) is followed by (0, 0).
  - `vsync_out` is high for `vcount_out` 725..729 only.
  - Total high cycles across the frame: 5 × 1650.
- Active region count: over one frame, `active_draw_out` is high for exactly 921,600 cycles. It is never high when `hcount_out ≥ 1280` or `vcount_out ≥ 720`.
- Frame counter wrap: run 64 frames → `frame_count_out` goes 63 → 0 on the 64th `new_frame_out`.
- Mid-frame reset and polarity:
  - Assert reset at (700, 400) → next cycle all outputs 0, and no `new_frame_out` pulse in between.
  - With `SYNC_POL=0`, the syncs are the inverse of the `SYNC_POL=1` run, and high during reset.
